// File: rtl/uart_pkg.sv
// Shared types and default timing constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } sched_state_e;

  // tx_start must outlast one tx_tick period at the slowest baud divisor.
  localparam int START_HOLD_DEF = 2048;
  // Cycles in WAIT before the transmitter is considered hung.
  localparam int TIMEOUT_DEF    = 2**20;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr (with wrap)
// that is both requesting and enabled by mask.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   index,
  output logic            any
);

  // Walk the requesters starting at ptr and take the first eligible one.
  always_comb begin
    logic [IW-1:0] j;
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!any && req[j] && mask[j]) begin
        gnt[j] = 1'b1;
        index  = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte sources,
// with packet lock, stretched tx_start and a watchdog on the done handshake.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int START_HOLD = START_HOLD_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  localparam int IW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        d_tx,
  input  logic              tx_done,
  output logic [IW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int HW = $clog2(START_HOLD + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_SEND = 2'(SEND);
  localparam logic [1:0] ST_WAIT = 2'(WAIT);

  logic [1:0]    state_reg, state_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [WW-1:0] wd_reg, wd_next;
  logic          lock_reg, lock_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] grant_reg, grant_next;
  logic [7:0]    d_tx_reg, d_tx_next;
  logic          done_seen_reg, done_seen_next;
  logic          timeout_reg, timeout_next;
  logic          tmo_set;

  logic          done_meta_reg, done_sync_reg, done_prev_reg, done_pulse_reg;

  logic [NREQ-1:0] elig_mask;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_index;
  logic            arb_any;
  logic [7:0]      req_byte [NREQ];

  // While a packet is locked only its owner stays eligible.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign elig_mask[gi] = ~lock_reg | (grant_reg == IW'(gi));
    assign req_byte[gi]  = req_data[8*gi +: 8];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .mask  (elig_mask),
    .ptr   (ptr_reg),
    .gnt   (arb_gnt),
    .index (arb_index),
    .any   (arb_any)
  );

  // Handshake is offered only in IDLE; reset masks it so it reads 0 while held.
  assign req_ready   = (state_reg == ST_IDLE && !reset) ? arb_gnt : '0;
  assign tx_start    = (state_reg == ST_SEND);
  assign busy        = (state_reg == ST_SEND) || (state_reg == ST_WAIT);
  assign d_tx        = d_tx_reg;
  assign grant_id    = grant_reg;
  assign timeout_err = timeout_reg;

  // Next-state logic for the grant / hold / wait sequence.
  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    wd_next        = wd_reg;
    lock_next      = lock_reg;
    ptr_next       = ptr_reg;
    grant_next     = grant_reg;
    d_tx_next      = d_tx_reg;
    done_seen_next = done_seen_reg;
    tmo_set        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          state_next     = ST_SEND;
          hold_next      = '0;
          d_tx_next      = req_byte[arb_index];
          grant_next     = arb_index;
          lock_next      = ~req_last[arb_index];
          ptr_next       = (arb_index == IW'(NREQ - 1)) ? '0 : arb_index + IW'(1);
          done_seen_next = 1'b0;
        end
      end
      ST_SEND: begin
        // A done that arrives while still holding tx_start is remembered for WAIT.
        if (done_pulse_reg) done_seen_next = 1'b1;
        if (hold_reg == HW'(START_HOLD - 1)) begin
          state_next = ST_WAIT;
          wd_next    = '0;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      ST_WAIT: begin
        if (done_pulse_reg || done_seen_reg) begin
          state_next     = ST_IDLE;
          done_seen_next = 1'b0;
        end else if (wd_reg == WW'(TIMEOUT - 1)) begin
          state_next = ST_IDLE;
          tmo_set    = 1'b1;
          lock_next  = 1'b0;
        end else begin
          wd_next = wd_reg + WW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Clearing wins over a simultaneous watchdog expiry.
    timeout_next = err_clr ? 1'b0 : (tmo_set ? 1'b1 : timeout_reg);
  end

  // State registers plus the tx_done synchroniser and rising-edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      hold_reg       <= '0;
      wd_reg         <= '0;
      lock_reg       <= 1'b0;
      ptr_reg        <= '0;
      grant_reg      <= '0;
      d_tx_reg       <= '0;
      done_seen_reg  <= 1'b0;
      timeout_reg    <= 1'b0;
      done_meta_reg  <= 1'b0;
      done_sync_reg  <= 1'b0;
      done_prev_reg  <= 1'b0;
      done_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_reg       <= hold_next;
      wd_reg         <= wd_next;
      lock_reg       <= lock_next;
      ptr_reg        <= ptr_next;
      grant_reg      <= grant_next;
      d_tx_reg       <= d_tx_next;
      done_seen_reg  <= done_seen_next;
      timeout_reg    <= timeout_next;
      done_meta_reg  <= tx_done;
      done_sync_reg  <= done_meta_reg;
      done_prev_reg  <= done_sync_reg;
      done_pulse_reg <= done_sync_reg & ~done_prev_reg;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: single byte, early done, round robin,
// packet lock, watchdog timeout, error clear priority and mid-send reset.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int HOLD = 32;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  d_tx;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.NREQ(NREQ), .START_HOLD(HOLD), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .d_tx        (d_tx),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  // Stimulus helper: wait (bounded) for a cycle with req_ready asserted.
  task automatic wait_accept(output logic [3:0] rdy);
    rdy = 4'b0000;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (req_ready != 4'b0000) begin
        rdy = req_ready;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Stimulus helper: count cycles with tx_start high, from the first SEND cycle.
  task automatic send_phase(output int cnt);
    cnt = 0;
    while (tx_start && cnt < 1000) begin
      cnt++;
      @(negedge clk);
      #1;
    end
  endtask

  // Stimulus helper: raise tx_done 10 cycles after tx_start fell; count cycles to idle.
  task automatic finish_byte(output int k);
    repeat (9) @(negedge clk);
    tx_done = 1'b1;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    tx_done = 1'b0; err_clr = 1'b0;
    @(negedge clk); #1;
    vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    vectors++; if (d_tx !== 8'h00) begin miscompares++; $display("FAIL reset_d_tx: got %h expected 00", d_tx); end
    vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    $display("reset: checked outputs");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] rdy;
    int cnt, k;
    req_valid = 4'b0001; req_data = 32'h0000_00A5; req_last = 4'b0001;
    wait_accept(rdy);
    vectors++; if (rdy !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b expected 0001", rdy); end
    @(negedge clk); #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL single_ready_one_cycle: got %b expected 0000", req_ready); end
    send_phase(cnt);
    req_valid = 4'b0000;
    vectors++; if (cnt !== HOLD) begin miscompares++; $display("FAIL single_hold: got %0d expected %0d", cnt, HOLD); end
    vectors++; if (d_tx !== 8'hA5) begin miscompares++; $display("FAIL single_d_tx: got %h expected a5", d_tx); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_wait: got %b expected 1", busy); end
    finish_byte(k);
    vectors++; if (k < 3 || k > 4) begin miscompares++; $display("FAIL single_done_latency: got %0d expected 3..4", k); end
    $display("single: grant 0 data %h hold %0d done->idle %0d", d_tx, cnt, k);
  endtask

  task automatic test_early_done();
    logic [3:0] rdy;
    int cnt;
    req_valid = 4'b0010; req_data = 32'h0000_9E00; req_last = 4'b0010;
    wait_accept(rdy);
    vectors++; if (rdy !== 4'b0010) begin miscompares++; $display("FAIL early_ready: got %b expected 0010", rdy); end
    @(negedge clk); #1;
    req_valid = 4'b0000;
    cnt = 0;
    while (tx_start && cnt < 1000) begin
      cnt++;
      if (cnt == 5) tx_done = 1'b1;
      if (cnt == 10) tx_done = 1'b0;
      @(negedge clk);
      #1;
    end
    vectors++; if (cnt !== HOLD) begin miscompares++; $display("FAIL early_hold: got %0d expected %0d", cnt, HOLD); end
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL early_done_consumed: got busy %b expected 0", busy); end
    $display("early_done: hold %0d busy %b", cnt, busy);
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy;
    int cnt, k, exp;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h1312_1110;
    for (int i = 0; i < 5; i++) begin
      exp = i % 4;
      wait_accept(rdy);
      vectors++; if (rdy !== 4'(1 << exp)) begin miscompares++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, rdy, 4'(1 << exp)); end
      @(negedge clk); #1;
      send_phase(cnt);
      vectors++; if (grant_id !== 2'(exp)) begin miscompares++; $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", i, grant_id, exp); end
      vectors++; if (d_tx !== 8'(8'h10 + exp)) begin miscompares++; $display("FAIL rr_d_tx[%0d]: got %h expected %h", i, d_tx, 8'(8'h10 + exp)); end
      if (i == 4) req_valid = 4'b0000;
      finish_byte(k);
      $display("round_robin: byte %0d grant %0d data %h", i, grant_id, d_tx);
    end
  endtask

  task automatic test_lock();
    logic [3:0] rdy;
    int cnt, k;
    req_valid = 4'b0101; req_last = 4'b0001; req_data = 32'h00C0_0055;
    for (int b = 0; b < 3; b++) begin
      wait_accept(rdy);
      vectors++; if (rdy !== 4'b0100) begin miscompares++; $display("FAIL lock_ready[%0d]: got %b expected 0100", b, rdy); end
      @(negedge clk); #1;
      send_phase(cnt);
      vectors++; if (d_tx !== 8'(8'hC0 + b)) begin miscompares++; $display("FAIL lock_d_tx[%0d]: got %h expected %h", b, d_tx, 8'(8'hC0 + b)); end
      req_data[23:16] = 8'(8'hC1 + b);
      req_last[2] = (b == 1);
      if (b == 2) req_valid[2] = 1'b0;
      finish_byte(k);
      $display("lock: byte %0d grant %0d data %h", b, grant_id, d_tx);
    end
    wait_accept(rdy);
    vectors++; if (rdy !== 4'b0001) begin miscompares++; $display("FAIL lock_release_ready: got %b expected 0001", rdy); end
    @(negedge clk); #1;
    send_phase(cnt);
    req_valid = 4'b0000;
    vectors++; if (d_tx !== 8'h55) begin miscompares++; $display("FAIL lock_release_d_tx: got %h expected 55", d_tx); end
    finish_byte(k);
    $display("lock: released, grant %0d data %h", grant_id, d_tx);
  endtask

  task automatic test_timeout();
    logic [3:0] rdy;
    int cnt, k;
    req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h0000_773C;
    wait_accept(rdy);
    vectors++; if (rdy !== 4'b0010) begin miscompares++; $display("FAIL tmo_ready: got %b expected 0010", rdy); end
    @(negedge clk); #1;
    send_phase(cnt);
    req_valid = 4'b0011; req_last = 4'b0001;
    k = 0;
    while (busy && k < 200) begin
      k++;
      @(negedge clk);
      #1;
    end
    vectors++; if (k !== TMO) begin miscompares++; $display("FAIL tmo_wait_cycles: got %0d expected %0d", k, TMO); end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_err_set: got %b expected 1", timeout_err); end
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL tmo_unlock_ready: got %b expected 0001", req_ready); end
    @(negedge clk); #1;
    send_phase(cnt);
    req_valid = 4'b0000;
    finish_byte(k);
    vectors++; if (d_tx !== 8'h3C) begin miscompares++; $display("FAIL tmo_next_d_tx: got %h expected 3c", d_tx); end
    $display("timeout: wait %0d err %b next data %h", TMO, timeout_err, d_tx);
  endtask

  task automatic test_err_clr();
    logic [3:0] rdy;
    int cnt, k;
    err_clr = 1'b1;
    @(negedge clk); #1;
    err_clr = 1'b0;
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL err_clr: got %b expected 0", timeout_err); end
    req_valid = 4'b1000; req_last = 4'b1000; req_data = 32'hE100_0000;
    wait_accept(rdy);
    vectors++; if (rdy !== 4'b1000) begin miscompares++; $display("FAIL clr_ready: got %b expected 1000", rdy); end
    @(negedge clk); #1;
    send_phase(cnt);
    req_valid = 4'b0000;
    k = 0;
    while (busy && k < 200) begin
      k++;
      if (k == TMO) err_clr = 1'b1;
      @(negedge clk);
      #1;
    end
    err_clr = 1'b0;
    vectors++; if (k !== TMO) begin miscompares++; $display("FAIL clr_wait_cycles: got %0d expected %0d", k, TMO); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL clr_priority: got %b expected 0", timeout_err); end
    $display("err_clr: simultaneous clear/timeout err %b", timeout_err);
  endtask

  task automatic test_reset_mid_send();
    logic [3:0] rdy;
    int cnt, k;
    req_valid = 4'b0010; req_last = 4'b0010; req_data = 32'h0000_4400;
    wait_accept(rdy);
    @(negedge clk); #1;
    req_valid = 4'b0000;
    send_phase(cnt);
    k = 0;
    while (busy && k < 200) begin
      k++;
      @(negedge clk);
      #1;
    end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL rst_pre_err: got %b expected 1", timeout_err); end
    req_valid = 4'b0100; req_last = 4'b0100;
    wait_accept(rdy);
    @(negedge clk); #1;
    vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL rst_pre_tx_start: got %b expected 1", tx_start); end
    reset = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'hDDCC_BBAA;
    #1;
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    @(negedge clk);
    reset = 1'b0;
    wait_accept(rdy);
    vectors++; if (rdy !== 4'b0001) begin miscompares++; $display("FAIL rst_first_grant: got %b expected 0001", rdy); end
    @(negedge clk); #1;
    req_valid = 4'b0000;
    send_phase(cnt);
    vectors++; if (d_tx !== 8'hAA) begin miscompares++; $display("FAIL rst_first_d_tx: got %h expected aa", d_tx); end
    finish_byte(k);
    $display("reset_mid_send: first grant after release %0d data %h", grant_id, d_tx);
  endtask

  initial begin
    test_reset();
    test_single();
    test_early_done();
    test_round_robin();
    test_lock();
    test_timeout();
    test_err_clr();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
